// File: rtl/lcd_ctrl_if.sv
// Control and strobe bundle between the LCD sequencer and the LCD datapath / panel pins.
// The sequencer drives everything and the datapath and panel only observe it.
interface lcd_ctrl_if;
    logic [1:0] init_sel;
    logic [1:0] mux_sel;
    logic       data_sel;
    logic       DB_sel;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       ready;
    logic       frame_done;

    modport master (
        output init_sel,
        output mux_sel,
        output data_sel,
        output DB_sel,
        output LCD_E,
        output LCD_RS,
        output LCD_RW,
        output ready,
        output frame_done
    );

    modport slave (
        input init_sel,
        input mux_sel,
        input data_sel,
        input DB_sel,
        input LCD_E,
        input LCD_RS,
        input LCD_RW,
        input ready,
        input frame_done
    );
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780-style LCD sequencer: power-up wait, 4-command init, then periodic
// frames of clear + 4 BCD digit writes, all with timed (non-polled) waits.
module lcd_ctrl #(
    parameter int CNT_W     = 23,
    parameter int T_PWRUP   = 750000,
    parameter int T_SETUP   = 2,
    parameter int T_EPW     = 12,
    parameter int T_HOLD    = 2,
    parameter int T_CMD     = 2000,
    parameter int T_CLR     = 82000,
    parameter int T_REFRESH = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    lcd_ctrl_if.master lcd
);

    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_WAIT  = 3'd4,
        S_IDLE  = 3'd5
    } state_t;

    // Counter reload values: a state lasts T_x cycles, exiting when the count reads 0.
    localparam logic [CNT_W-1:0] LD_PWRUP   = CNT_W'(T_PWRUP - 1);
    localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_EPW     = CNT_W'(T_EPW - 1);
    localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_CMD     = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] LD_CLR     = CNT_W'(T_CLR - 1);
    localparam logic [CNT_W-1:0] LD_REFRESH = CNT_W'(T_REFRESH - 1);

    localparam logic [2:0] STEP_CLEAR = 3'd3;
    localparam logic [2:0] STEP_LAST  = 3'd7;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       step_q, step_d;
    logic [1:0]       init_sel_q, init_sel_d;
    logic [1:0]       mux_sel_q, mux_sel_d;
    logic             ready_q, ready_d;
    logic             frame_done_q, frame_done_d;
    logic             cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_PWRUP;
            cnt_q        <= LD_PWRUP;
            step_q       <= 3'd0;
            init_sel_q   <= 2'b11;
            mux_sel_q    <= 2'b11;
            ready_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            init_sel_q   <= init_sel_d;
            mux_sel_q    <= mux_sel_d;
            ready_q      <= ready_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q - CNT_W'(1);
        step_d       = step_q;
        ready_d      = ready_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_PWRUP: begin
                if (cnt_zero) begin
                    state_d = S_SETUP;
                    cnt_d   = LD_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_zero) begin
                    state_d = S_PULSE;
                    cnt_d   = LD_EPW;
                end
            end
            S_PULSE: begin
                if (cnt_zero) begin
                    state_d = S_HOLD;
                    cnt_d   = LD_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_zero) begin
                    state_d = S_WAIT;
                    cnt_d   = (step_q == STEP_CLEAR) ? LD_CLR : LD_CMD;
                end
            end
            S_WAIT: begin
                if (cnt_zero) begin
                    if (step_q == STEP_LAST) begin
                        state_d      = S_IDLE;
                        cnt_d        = LD_REFRESH;
                        frame_done_d = 1'b1;
                        ready_d      = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                        cnt_d   = LD_SETUP;
                        step_d  = step_q + 3'd1;
                    end
                end
            end
            S_IDLE: begin
                // A refresh frame skips the init commands and starts at clear.
                if (cnt_zero) begin
                    state_d = S_SETUP;
                    cnt_d   = LD_SETUP;
                    step_d  = STEP_CLEAR;
                end
            end
            default: begin
                state_d = S_PWRUP;
                cnt_d   = LD_PWRUP;
                step_d  = 3'd0;
            end
        endcase
    end

    // Step decode, registered alongside step so selects never glitch; unused
    // select keeps its previous value.
    always_comb begin
        init_sel_d = init_sel_q;
        mux_sel_d  = mux_sel_q;
        case (step_d)
            3'd0:    init_sel_d = 2'b11;
            3'd1:    init_sel_d = 2'b01;
            3'd2:    init_sel_d = 2'b10;
            3'd3:    init_sel_d = 2'b00;
            default: mux_sel_d  = ~step_d[1:0];
        endcase
    end

    // Output logic
    always_comb begin
        lcd.init_sel   = init_sel_q;
        lcd.mux_sel    = mux_sel_q;
        lcd.data_sel   = step_q[2];
        lcd.DB_sel     = 1'b0;
        lcd.LCD_E      = 1'b0;
        lcd.LCD_RS     = 1'b0;
        lcd.LCD_RW     = 1'b0;
        lcd.ready      = ready_q;
        lcd.frame_done = frame_done_q;
        case (state_q)
            S_SETUP, S_HOLD: begin
                lcd.DB_sel = 1'b1;
                lcd.LCD_RS = step_q[2];
            end
            S_PULSE: begin
                lcd.DB_sel = 1'b1;
                lcd.LCD_RS = step_q[2];
                lcd.LCD_E  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl with shortened timing; models the downstream
// datapath byte and checks E pulses, frame timing and asynchronous reset.
module tb_lcd_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_ctrl_if bus ();

    lcd_ctrl #(
        .CNT_W    (23),
        .T_PWRUP  (10),
        .T_SETUP  (2),
        .T_EPW    (3),
        .T_HOLD   (1),
        .T_CMD    (5),
        .T_CLR    (20),
        .T_REFRESH(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lcd(bus.master)
    );

    logic [3:0] cnt3, cnt2, cnt1, cnt0;
    int checks   = 0;
    int failures = 0;
    int edge_cnt;

    // Cycle n = the clock period that ends at the n-th rising edge after reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    typedef struct {
        logic [3:0] c3, c2, c1, c0;
        int         rise;
        logic [7:0] db;
        logic       rs;
    } vec_t;

    vec_t vt [13];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic finish_now();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Byte the downstream datapath would put on DB for the current selects.
    function automatic logic [7:0] db_byte();
        logic [3:0] d;
        if (!bus.DB_sel) return 8'hCC;
        if (bus.data_sel) begin
            case (bus.mux_sel)
                2'b11:   d = cnt3;
                2'b10:   d = cnt2;
                2'b01:   d = cnt1;
                default: d = cnt0;
            endcase
            return 8'h30 + {4'h0, d};
        end
        case (bus.init_sel)
            2'b11:   return 8'h38;
            2'b01:   return 8'h0E;
            2'b10:   return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    task automatic wait_rise(input int limit, output int c, output bit ok);
        ok = 1'b0;
        c  = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.LCD_E) begin
                ok = 1'b1;
                c  = edge_cnt;
                return;
            end
        end
    endtask

    task automatic wait_fd(input int limit, output int c, output bit ok);
        ok = 1'b0;
        c  = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.frame_done) begin
                ok = 1'b1;
                c  = edge_cnt;
                return;
            end
        end
    endtask

    // Bus invariants sampled every cycle outside reset.
    logic e_p, db_p1, db_p2, rs_p1, rs_p2;
    always @(negedge clk) begin
        if (rst) begin
            e_p = 1'b0; db_p1 = 1'b0; db_p2 = 1'b0; rs_p1 = 1'b0; rs_p2 = 1'b0;
        end else begin
            check("rw_low", bus.LCD_RW, 0);
            if (bus.LCD_E && !e_p)
                check("e_setup", (db_p1 && db_p2 && rs_p1 == bus.LCD_RS && rs_p2 == bus.LCD_RS), 1);
            db_p2 = db_p1; db_p1 = bus.DB_sel;
            rs_p2 = rs_p1; rs_p1 = bus.LCD_RS;
            e_p   = bus.LCD_E;
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_E"},        bus.LCD_E, 0);
        check({tag, "_RS"},       bus.LCD_RS, 0);
        check({tag, "_RW"},       bus.LCD_RW, 0);
        check({tag, "_DB_sel"},   bus.DB_sel, 0);
        check({tag, "_data_sel"}, bus.data_sel, 0);
        check({tag, "_init_sel"}, bus.init_sel, 3);
        check({tag, "_mux_sel"},  bus.mux_sel, 3);
        check({tag, "_ready"},    bus.ready, 0);
        check({tag, "_fd"},       bus.frame_done, 0);
    endtask

    initial begin
        int  c, w, fall, prev_fall;
        bit  ok, stable;
        logic [7:0] b;

        vt[0]  = '{4'd1, 4'd2, 4'd3, 4'd4,  12, 8'h38, 1'b0};
        vt[1]  = '{4'd1, 4'd2, 4'd3, 4'd4,  23, 8'h0E, 1'b0};
        vt[2]  = '{4'd1, 4'd2, 4'd3, 4'd4,  34, 8'h06, 1'b0};
        vt[3]  = '{4'd1, 4'd2, 4'd3, 4'd4,  45, 8'h01, 1'b0};
        vt[4]  = '{4'd1, 4'd2, 4'd3, 4'd4,  71, 8'h31, 1'b1};
        vt[5]  = '{4'd1, 4'd2, 4'd3, 4'd4,  82, 8'h32, 1'b1};
        vt[6]  = '{4'd1, 4'd2, 4'd3, 4'd4,  93, 8'h33, 1'b1};
        vt[7]  = '{4'd1, 4'd2, 4'd3, 4'd4, 104, 8'h34, 1'b1};
        vt[8]  = '{4'd9, 4'd0, 4'd0, 4'd5, 165, 8'h01, 1'b0};
        vt[9]  = '{4'd9, 4'd0, 4'd0, 4'd5, 191, 8'h39, 1'b1};
        vt[10] = '{4'd9, 4'd0, 4'd0, 4'd5, 202, 8'h30, 1'b1};
        vt[11] = '{4'd9, 4'd0, 4'd0, 4'd5, 213, 8'h30, 1'b1};
        vt[12] = '{4'd9, 4'd0, 4'd0, 4'd5, 224, 8'h35, 1'b1};

        cnt3 = 4'd1; cnt2 = 4'd2; cnt1 = 4'd3; cnt0 = 4'd4;
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("rst0");
        rst = 1'b0;

        // Run into the second frame, then reset in the middle of its first E pulse.
        wait_fd(400, c, ok);
        check("pre_fd_seen", ok, 1);
        if (!ok) finish_now();
        check("pre_fd_cycle", c, 113);
        wait_rise(200, c, ok);
        check("pre_rise_seen", ok, 1);
        if (!ok) finish_now();
        check("pre_rise_cycle", c, 165);
        check("pre_ready", bus.ready, 1);
        #2 rst = 1'b1;
        #1;
        check("midpulse_E", bus.LCD_E, 0);
        check("midpulse_DB_sel", bus.DB_sel, 0);
        repeat (2) @(negedge clk);
        check_reset_values("rst1");
        rst = 1'b0;

        // Table-driven run of two full frames after the restart.
        prev_fall = 0;
        for (int i = 0; i < 13; i++) begin
            cnt3 = vt[i].c3; cnt2 = vt[i].c2; cnt1 = vt[i].c1; cnt0 = vt[i].c0;
            wait_rise(300, c, ok);
            check($sformatf("v%0d_seen", i), ok, 1);
            if (!ok) finish_now();
            check($sformatf("v%0d_rise", i), c, vt[i].rise);
            check($sformatf("v%0d_db", i), db_byte(), vt[i].db);
            check($sformatf("v%0d_rs", i), bus.LCD_RS, vt[i].rs);
            if (i == 0) check("v0_ready_low", bus.ready, 0);
            if (i == 4 || i == 9) check($sformatf("v%0d_gap_after_clear", i), c - prev_fall, 23);
            if (i >= 1 && i <= 3) check($sformatf("v%0d_cmd_spacing", i), c - vt[i-1].rise, 11);
            w = 1;
            stable = 1'b1;
            b = db_byte();
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (!bus.LCD_E) break;
                w++;
                if (db_byte() != b) stable = 1'b0;
            end
            fall = edge_cnt;
            prev_fall = fall;
            check($sformatf("v%0d_width", i), w, 3);
            check($sformatf("v%0d_stable", i), stable, 1);
            if (i == 7 || i == 12) begin
                wait_fd(100, c, ok);
                check($sformatf("v%0d_fd_seen", i), ok, 1);
                if (!ok) finish_now();
                check($sformatf("v%0d_fd_cycle", i), c, (i == 7) ? 113 : 233);
                check($sformatf("v%0d_ready", i), bus.ready, 1);
                @(negedge clk);
                check($sformatf("v%0d_fd_one_cycle", i), bus.frame_done, 0);
                check($sformatf("v%0d_ready_sticky", i), bus.ready, 1);
            end
        end

        finish_now();
    end

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Sequencing FSM directly upstream of the LCD datapath (`LCD_dp`).
- Drives `init_sel`, `mux_sel`, `data_sel` and `DB_sel` into the datapath, and drives the HD44780-style bus strobes `LCD_E`, `LCD_RS` and `LCD_RW` to the panel pins.
- After reset it runs the power-up wait and the 4-command init: function set, display on, entry mode, clear.
- It then writes the four BCD digits `count3`..`count0` and refreshes periodically with clear followed by 4 digit writes.

Parameters:
- CNT_W, 23, width of the shared timing down-counter.
- T_PWRUP, 750000, power-up wait in clk cycles (15 ms @ 50 MHz).
- T_SETUP, 2, RS/DB setup before E rises.
- T_EPW, 12, E high pulse width.
- T_HOLD, 2, RS/DB hold after E falls.
- T_CMD, 2000, post-write wait for ordinary command or data (40 us).
- T_CLR, 82000, post-write wait after clear (1.64 ms).
- T_REFRESH, 5000000, idle time between display frames.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- init_sel  out  2  command select to datapath: 11=0x38, 01=0x0E, 10=0x06, 00=0x01.
- mux_sel  out  2  digit select to datapath: 11=count3 … 00=count0.
- data_sel  out  1  1=digit character, 0=init command.
- DB_sel  out  1  1=datapath drives byte, 0=idle pattern 0xCC.
- LCD_E  out  1  enable strobe.
- LCD_RS  out  1  register select; equals data_sel while a byte is on the bus.
- LCD_RW  out  1  constant 0 (write only).
- ready  out  1  high from the first completed frame onward.
- frame_done  out  1  one-cycle pulse at the end of every frame.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-pulse):
  - LCD_E=0, LCD_RS=0, LCD_RW=0, DB_sel=0, data_sel=0.
  - init_sel=11, mux_sel=11, ready=0, frame_done=0.
  - state=PWRUP, step=0, counter=T_PWRUP-1.
  - Any reset restarts the full power-up plus init sequence.
- Timed states: on entry the counter loads T_x-1 and decrements each cycle; the state exits on the cycle the counter reads 0. Each state therefore lasts exactly T_x cycles.
- States:
  - PWRUP: all strobes low, DB_sel=0. Exits to SETUP.
  - SETUP: DB_sel=1, LCD_RS=data_sel, LCD_E=0. Duration T_SETUP. Exits to PULSE.
  - PULSE: as SETUP but LCD_E=1. Duration T_EPW. Exits to HOLD.
  - HOLD: as SETUP, LCD_E=0. Duration T_HOLD. Exits to WAIT.
  - WAIT: DB_sel=0, LCD_RS=0, LCD_E=0.
    - Duration is T_CLR when step=3, else T_CMD.
    - On exit, if step<7: step++ and go to SETUP.
    - If step=7: pulse frame_done, set ready=1 (sticky), go to IDLE.
  - IDLE: strobes low, DB_sel=0. Duration T_REFRESH. Exits with step=3, to SETUP.
- Step decode (3-bit step, combinational from step and held through SETUP/PULSE/HOLD/WAIT):
  - 0: init_sel=11, data_sel=0.
  - 1: init_sel=01, data_sel=0.
  - 2: init_sel=10, data_sel=0.
  - 3: init_sel=00, data_sel=0 (clear, returns cursor home).
  - 4..7: data_sel=1, mux_sel = 3-(step-4), i.e. count3, count2, count1, count0 left to right.
- Only the values listed in the step decode drive the datapath; init_sel and mux_sel keep their last value otherwise.
- Digits are not latched here. Each digit byte is stable on DB only for the duration of its own SETUP..HOLD window.
- LCD_E never rises unless DB_sel=1 and LCD_RS has already been stable for T_SETUP cycles.
- There is no busy-flag readback: LCD_RW is tied 0 and all waits are timed.

Test Plan:
- Test parameters used below: T_PWRUP=10, T_SETUP=2, T_EPW=3, T_HOLD=1, T_CMD=5, T_CLR=20, T_REFRESH=50; cycle 0 = first clk edge with rst low.
- Reset then release -> outputs at reset values; first LCD_E rise at cycle 12; E high for exactly 3 cycles with DB=0x38, RS=0.
- Full init -> E pulses carry 0x38, 0x0E, 0x06, 0x01 (RS=0), then digits 0x30+count3..count0 (RS=1); ready and frame_done assert at cycle 113 (10+3·11+26+4·11).
- count3..0 = 1,2,3,4 -> digit bytes 0x31, 0x32, 0x33, 0x34 in that order; change counts to 9,0,0,5 during IDLE -> next frame shows 0x01, then 0x39, 0x30, 0x30, 0x35, with frame_done at cycle 233.
- Gap check -> clear-to-next-E-rise spacing is 20+1+2=23 cycles; command-to-command spacing is 11 cycles; LCD_RW=0 throughout.
- Assert rst while LCD_E=1 in the second frame -> LCD_E=0 and DB_sel=0 in the same cycle; after release, ready=0 and the sequence restarts with PWRUP and 0x38 at cycle 12.
